// File: rtl/tt_pkg.sv
// tt_pkg: shared types and helpers for the truth-table sequencer.
//   tt_state_t        sweep FSM states
//   TT_MAX_INPUTS     largest supported N_INPUTS
//   settle_cnt_width  width of the settle down-counter for a given SETTLE_CYCLES
package tt_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} tt_state_t;

   localparam int unsigned TT_MAX_INPUTS = 8;

   // The counter is loaded with SETTLE_CYCLES-1, so it only needs to hold that value.
   function automatic int unsigned settle_cnt_width(input int unsigned settle_cycles);
      return (settle_cycles <= 2) ? 1 : $clog2(settle_cycles);
   endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: loadable down-counter that times how long a stimulus vector is held.
//   clk_i     rising-edge clock
//   reset_i   synchronous active-high reset
//   load_i    reload the counter with SETTLE_CYCLES-1 (asserted while outside DRIVE)
//   run_i     count down (asserted while in DRIVE)
//   expire_o  high in the last settle cycle of a DRIVE phase
module tt_settle_timer
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic load_i,
   input  logic run_i,
   output logic expire_o
);

   localparam int unsigned W = settle_cnt_width(SETTLE_CYCLES);
   localparam logic [W-1:0] LoadVal = W'(SETTLE_CYCLES - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= LoadVal;
      end else if (run_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps every input combination of a small combinational DUT,
// samples its single-bit result and compares it against the TRUTH table.
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      begin a sweep (honoured only in IDLE or DONE)
//   stim       vector driven to the DUT (MSB = stim[N_INPUTS-1])
//   dut_r      DUT result, sampled only in SAMPLE
//   busy       sweep in progress
//   done       sweep finished, held until next accepted start or reset
//   pass       valid with done: no mismatches
//   err_count  mismatching vectors in the current/last sweep
//   first_fail index of the first mismatching vector (valid when err_count != 0)
// Build option: define TT_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module truth_table_sequencer
   import tt_pkg::*;
#(
   parameter int unsigned                N_INPUTS      = 2,
   parameter logic [(2**N_INPUTS)-1:0]   TRUTH         = 4'b0111,
   parameter int unsigned                SETTLE_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic [N_INPUTS-1:0] stim,
   input  logic                dut_r,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [N_INPUTS:0]   err_count,
   output logic [N_INPUTS-1:0] first_fail
);

   localparam logic [N_INPUTS-1:0] LastIdx = '1;

   tt_state_t           state_q;
   logic [N_INPUTS-1:0] idx_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;
   logic [N_INPUTS:0]   err_q;
   logic [N_INPUTS-1:0] ff_q;
   logic                settle_expire;
   logic                mismatch;
   logic                sweep_end;

   tt_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle (
      .clk_i   (clk),
      .reset_i (reset),
      .load_i  (state_q != DRIVE),
      .run_i   (state_q == DRIVE),
      .expire_o(settle_expire)
   );

   assign mismatch = (dut_r != TRUTH[idx_q]);

`ifdef TT_STOP_ON_FAIL_EN
   assign sweep_end = mismatch || (idx_q == LastIdx);
`else
   assign sweep_end = (idx_q == LastIdx);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ff_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= DRIVE;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  err_q   <= '0;
                  ff_q    <= '0;
               end
            end
            DRIVE: begin
               if (settle_expire) begin
                  state_q <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (mismatch) begin
                  err_q <= err_q + 1'b1;
                  if (err_q == '0) begin
                     ff_q <= idx_q;
                  end
               end
               if (sweep_end) begin
                  // idx_q is left on the last driven vector so stim holds in DONE.
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_q == '0) && !mismatch;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= DRIVE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stim       = idx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;

   // Instance A: defaults (2-input NAND, 1 settle cycle)
   logic [1:0] stim_a;
   logic       busy_a, done_a, pass_a, dut_r_a;
   logic [2:0] err_a;
   logic [1:0] ff_a;
   logic [3:0] tbl_a = 4'b0111;

   // Instance B: 3-input AND, 2 settle cycles
   logic [2:0] stim_b;
   logic       busy_b, done_b, pass_b, dut_r_b;
   logic [3:0] err_b;
   logic [2:0] ff_b;
   logic [7:0] tbl_b = 8'h80;

   int total = 0;
   int bad = 0;
   int cur = 0;

   always #5 clk = ~clk;

   // The simulated gate network under test is just a lookup of its own truth table.
   assign dut_r_a = tbl_a[stim_a];
   assign dut_r_b = tbl_b[stim_b];

   truth_table_sequencer u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .start     (start_a),
      .stim      (stim_a),
      .dut_r     (dut_r_a),
      .busy      (busy_a),
      .done      (done_a),
      .pass      (pass_a),
      .err_count (err_a),
      .first_fail(ff_a)
   );

   truth_table_sequencer #(
      .N_INPUTS     (3),
      .TRUTH        (8'b1000_0000),
      .SETTLE_CYCLES(2)
   ) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .start     (start_b),
      .stim      (stim_b),
      .dut_r     (dut_r_b),
      .busy      (busy_b),
      .done      (done_b),
      .pass      (pass_b),
      .err_count (err_b),
      .first_fail(ff_b)
   );

   logic       s_busy, s_done, s_pass;
   logic [2:0] s_stim, s_ff;
   logic [3:0] s_err;

   always_comb begin
      s_busy = (cur != 0) ? busy_b : busy_a;
      s_done = (cur != 0) ? done_b : done_a;
      s_pass = (cur != 0) ? pass_b : pass_a;
      s_stim = (cur != 0) ? stim_b : {1'b0, stim_a};
      s_ff   = (cur != 0) ? ff_b   : {1'b0, ff_a};
      s_err  = (cur != 0) ? err_b  : {1'b0, err_a};
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (inst %0d, t=%0t)", tag, got, exp, cur, $time);
      end
   endtask

   task automatic check_idle_state(input string tag);
      check_eq({tag, "_busy"}, 32'(s_busy), 32'd0);
      check_eq({tag, "_done"}, 32'(s_done), 32'd0);
      check_eq({tag, "_pass"}, 32'(s_pass), 32'd0);
      check_eq({tag, "_err"},  32'(s_err),  32'd0);
      check_eq({tag, "_ff"},   32'(s_ff),   32'd0);
      check_eq({tag, "_stim"}, 32'(s_stim), 32'd0);
   endtask

   // One sweep on instance `which` with DUT behaviour `tbl`. repulse_at / reset_at give the
   // zero-based busy cycle at which to pulse start again / assert reset (-1 = never).
   task automatic run_sweep(input int which, input logic [7:0] tbl, input int repulse_at,
                            input int reset_at);
      int v, s, n, errs, ff, last;
      logic [7:0] truth, mask, mism;
      cur = which;
      if (which == 0) begin
         v = 4; s = 1; truth = 8'h07; mask = 8'h0F; tbl_a = tbl[3:0];
      end else begin
         v = 8; s = 2; truth = 8'h80; mask = 8'hFF; tbl_b = tbl;
      end

      // Reference: mismatches are the bits where the gate differs from the table.
      mism = (tbl ^ truth) & mask;
      errs = 0;
      ff   = 0;
      for (int i = 0; i < v; i++) begin
         if (mism[i]) begin
            if (errs == 0) ff = i;
            errs++;
         end
      end
      last = v - 1;
`ifdef TT_STOP_ON_FAIL_EN
      if (errs > 0) begin
         errs = 1;
         last = ff;
      end
`endif

      @(negedge clk);
      if (which == 0) start_a = 1'b1; else start_b = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      n = 0;
      while (s_busy && n < 200) begin
         if (n == reset_at) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_idle_state("abort");
            return;
         end
         check_eq("stim_seq", 32'(s_stim), 32'(n / (s + 1)));
         if (n == repulse_at) begin
            if (which == 0) start_a = 1'b1; else start_b = 1'b1;
         end else begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      start_a = 1'b0;
      start_b = 1'b0;
      check_eq("busy_cycles", 32'(n), 32'((last + 1) * (s + 1)));
      check_eq("done", 32'(s_done), 32'd1);
      check_eq("pass", 32'(s_pass), 32'(errs == 0));
      check_eq("err_count", 32'(s_err), 32'(errs));
      if (errs != 0) check_eq("first_fail", 32'(s_ff), 32'(ff));
      check_eq("stim_hold", 32'(s_stim), 32'(last));
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      cur = 0;
      check_idle_state("reset_a");
      cur = 1;
      check_idle_state("reset_b");
      reset = 1'b0;

      run_sweep(0, 8'h07, -1, -1);  // correct NAND
      run_sweep(0, 8'h06, -1, -1);  // XOR
      run_sweep(0, 8'h0F, -1, -1);  // stuck-at-1
      run_sweep(0, 8'h00, -1, -1);  // stuck-at-0
      run_sweep(0, 8'h07, 2, -1);   // start re-pulsed while busy
      run_sweep(0, 8'h07, -1, 4);   // reset mid-sweep
      for (int k = 0; k < 8; k++) run_sweep(0, 8'($urandom_range(0, 15)), -1, -1);

      run_sweep(1, 8'h80, -1, -1);  // correct 3-input AND
      for (int k = 0; k < 6; k++) run_sweep(1, 8'($urandom), -1, -1);
      run_sweep(1, 8'h80, -1, 9);   // reset mid-sweep on the wider block

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
